// File: rtl/mining_pkg.sv
// mining_pkg: shared widths, work-unit field offsets, FSM encoding and result record
package mining_pkg;
  localparam int HASH_W = 256;
  localparam int NONCE_W = 32;
  localparam int X_W = 256;
  localparam int Y_W = 96;
  localparam int WORK_W = 352;
  localparam int JOB_W = 8;
  localparam int X_LSB = 0;
  localparam int Y_LSB = 256;
  localparam int RES_W = HASH_W + NONCE_W + JOB_W;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_BLANK, S_RUN, S_DONE} state_t;
  typedef struct packed {
    logic [HASH_W-1:0] hash;
    logic [NONCE_W-1:0] nonce;
    logic [JOB_W-1:0] job;
  } result_t;
endpackage

// File: rtl/mining_dispatcher_if.sv
// mining_dispatcher_if: work, core and result signals of the dispatcher
//   slave  = dispatcher side, master = UART/core environment side
interface mining_dispatcher_if #(parameter int N_CORES = 4) ();
  import mining_pkg::*;
  logic work_valid;
  logic [WORK_W-1:0] work_data;
  logic [X_W-1:0] core_x;
  logic [Y_W-1:0] core_y;
  logic [NONCE_W*N_CORES-1:0] core_nonce;
  logic [N_CORES-1:0] core_accepted;
  logic [HASH_W*N_CORES-1:0] core_hash;
  logic [NONCE_W*N_CORES-1:0] core_out_nonce;
  logic res_valid;
  logic res_ready;
  logic [HASH_W-1:0] res_hash;
  logic [NONCE_W-1:0] res_nonce;
  logic [JOB_W-1:0] res_job;
  logic busy;
  logic exhausted;
  logic [15:0] drop_count;
  modport slave (
    input work_valid, work_data, core_accepted, core_hash, core_out_nonce, res_ready,
    output core_x, core_y, core_nonce, res_valid, res_hash, res_nonce, res_job, busy, exhausted, drop_count
  );
  modport master (
    output work_valid, work_data, core_accepted, core_hash, core_out_nonce, res_ready,
    input core_x, core_y, core_nonce, res_valid, res_hash, res_nonce, res_job, busy, exhausted, drop_count
  );
endinterface

// File: rtl/result_fifo.sv
// result_fifo: show-ahead synchronous FIFO, async active-low reset
//   push/din write when not full (or when popping), pop/dout read the head, empty/full flags
module result_fifo #(
  parameter int W = 296,
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic [W-1:0] din,
  input  logic pop,
  output logic [W-1:0] dout,
  output logic empty,
  output logic full
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic wr, rd;
  assign empty = wp == rp;
  assign full = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
  assign wr = push && (!full || pop);
  assign rd = pop && !empty;
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wr ? wp + (AW+1)'(1) : wp;
      rp <= rd ? rp + (AW+1)'(1) : rp;
    end
  always_ff @(posedge clk)
    if (wr) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/mining_dispatcher.sv
// mining_dispatcher: broadcasts a work unit to N_CORES hash cores, interleaves nonces, buffers hits
//   clk, rst_n (async active-low)
//   bus.work_valid/work_data  : work unit in ({Y, X})
//   bus.core_x/core_y/core_nonce, core_accepted, core_hash/core_out_nonce : core side
//   bus.res_valid/res_ready/res_hash/res_nonce/res_job : result stream out
//   bus.busy, bus.exhausted, bus.drop_count : status
module mining_dispatcher #(
  parameter int N_CORES = 4,
  parameter int LOG2_CORES = 2,
  parameter int DIFF_BITS = 32,
  parameter int PIPE_LAT = 128,
  parameter int FIFO_DEPTH = 8
) (
  input logic clk,
  input logic rst_n,
  mining_dispatcher_if.slave bus
);
  import mining_pkg::*;
  localparam int KW = NONCE_W - LOG2_CORES;
  localparam int PW = LOG2_CORES > 0 ? LOG2_CORES : 1;
  localparam int CW = PIPE_LAT > 1 ? $clog2(PIPE_LAT) : 1;
  state_t state, state_nx;
  logic [CW-1:0] blank_cnt;
  logic [JOB_W-1:0] job;
  logic [WORK_W-1:0] work_q;
  logic [N_CORES-1:0] done, hit, cap_full, grant, drop;
  result_t cap [N_CORES];
  result_t head;
  logic [PW-1:0] rr, win, idx;
  logic any_full, push, fifo_full, fifo_empty, screen, ld;
  logic [4:0] n_drop;
  logic [16:0] dsum;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = bus.work_valid ? S_LOAD :
               state == S_LOAD ? S_BLANK :
               state == S_BLANK && blank_cnt == CW'(PIPE_LAT - 1) ? S_RUN :
               state == S_RUN && &done ? S_DONE : state;
  end
  always_comb begin
    ld = state == S_LOAD;
    screen = state == S_RUN || state == S_DONE;
    bus.busy = state == S_BLANK || state == S_RUN;
    bus.exhausted = state == S_DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      work_q <= '0;
      blank_cnt <= '0;
      job <= '0;
      rr <= '0;
      bus.core_x <= '0;
      bus.core_y <= '0;
      bus.drop_count <= '0;
    end else begin
      if (bus.work_valid) work_q <= bus.work_data;
      blank_cnt <= ld ? '0 : state == S_BLANK ? blank_cnt + CW'(1) : blank_cnt;
      if (ld) begin
        job <= job + JOB_W'(1);
        bus.core_x <= work_q[X_LSB +: X_W];
        bus.core_y <= work_q[Y_LSB +: Y_W];
      end
      if (push) rr <= PW'((int'(win) + 1) % N_CORES);
      bus.drop_count <= dsum[16] ? 16'hFFFF : dsum[15:0];
    end
  for (genvar i = 0; i < N_CORES; i++) begin : g_core
    logic [KW-1:0] k;
    logic d, full;
    result_t c;
    assign hit[i] = screen && bus.core_hash[HASH_W*i+HASH_W-1 -: DIFF_BITS] == '0;
    assign drop[i] = hit[i] && full && !grant[i];
    assign done[i] = d;
    assign cap_full[i] = full;
    assign cap[i] = c;
    assign bus.core_nonce[NONCE_W*i +: NONCE_W] = state == S_IDLE ? '0 : (NONCE_W'(k) << LOG2_CORES) | NONCE_W'(i);
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        k <= '0;
        d <= 1'b0;
        full <= 1'b0;
        c <= '0;
      end else begin
        if (ld) begin
          k <= '0;
          d <= 1'b0;
        end else if (bus.core_accepted[i] && !d && state != S_IDLE) begin
          k <= &k ? k : k + KW'(1);
          d <= &k;
        end
        // a capture being drained this cycle can take the new hit without a drop
        if (ld) full <= 1'b0;
        else if (hit[i] && (!full || grant[i])) begin
          full <= 1'b1;
          c <= '{hash: bus.core_hash[HASH_W*i +: HASH_W], nonce: bus.core_out_nonce[NONCE_W*i +: NONCE_W], job: job};
        end else if (grant[i]) full <= 1'b0;
      end
  end
  // round-robin search starting at rr; the pointer moves only on an actual FIFO write
  always_comb begin
    win = rr;
    idx = rr;
    any_full = 1'b0;
    for (int j = 0; j < N_CORES; j++) begin
      idx = PW'((int'(rr) + j) % N_CORES);
      if (!any_full && cap_full[idx]) begin
        any_full = 1'b1;
        win = idx;
      end
    end
    push = any_full && (!fifo_full || bus.res_ready);
    grant = push ? N_CORES'(1) << win : '0;
  end
  assign n_drop = 5'($countones(drop));
  assign dsum = {1'b0, bus.drop_count} + 17'(n_drop);
  result_fifo #(.W(RES_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .din(cap[win]),
    .pop(bus.res_ready && !fifo_empty),
    .dout(head),
    .empty(fifo_empty),
    .full(fifo_full)
  );
  assign bus.res_valid = !fifo_empty;
  assign bus.res_hash = fifo_empty ? '0 : head.hash;
  assign bus.res_nonce = fifo_empty ? '0 : head.nonce;
  assign bus.res_job = fifo_empty ? '0 : head.job;
endmodule
